// File: rtl/rv_dmem_pkg.sv
// Shared types and helpers for the data-memory responder.
// Holds the FSM state type, size masks and the request legality check.
package rv_dmem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } t_dmem_state;

    localparam logic [3:0] BE_BYTE = 4'b0001;
    localparam logic [3:0] BE_HALF = 4'b0011;
    localparam logic [3:0] BE_WORD = 4'b1111;

    function automatic logic f_illegal(
        input logic       rd,
        input logic       wr,
        input logic [3:0] be,
        input logic [1:0] lo
    );
        logic bad;
        bad = (rd == wr);
        case (be)
            BE_BYTE: bad = bad;
            BE_HALF: bad = bad | lo[0];
            BE_WORD: bad = bad | (lo != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/rv_dmem_align.sv
// Load lane extraction: shift the word down to the addressed byte,
// mask to the access size and zero- or sign-extend to 32 bits.
module rv_dmem_align
    import rv_dmem_pkg::*;
(
    input  logic [31:0] i_word,
    input  logic [1:0]  i_off,
    input  logic [3:0]  i_be,
    input  logic        i_sext,
    output logic [31:0] o_data
);

    logic [31:0] w_shift;

    always_comb begin
        w_shift = i_word >> {i_off, 3'b000};
        o_data  = w_shift;
        case (i_be)
            BE_BYTE: o_data = {{24{i_sext & w_shift[7]}}, w_shift[7:0]};
            BE_HALF: o_data = {{16{i_sext & w_shift[15]}}, w_shift[15:0]};
            default: o_data = w_shift;
        endcase
    end

endmodule

// File: rtl/rv_dmem_resp.sv
// Single-port data memory with a valid/ready request side, a fixed
// number of wait states and a one-cycle response pulse.
module rv_dmem_resp
    import rv_dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic        req_rd_en,
    input  logic        req_wr_en,
    input  logic [3:0]  req_byte_en,
    input  logic        req_sign_ext,
    input  logic [31:0] req_wr_data,
    output logic        rsp_valid,
    output logic [31:0] rsp_rd_data,
    output logic        rsp_err
);

    localparam int          AW = $clog2(DEPTH_WORDS);
    localparam logic [2:0]  WC = 3'(WAIT_CYCLES);

    t_dmem_state r_state;
    t_dmem_state w_next;
    logic [2:0]  r_cnt;
    logic [2:0]  w_cnt_nxt;

    logic [AW-1:0] r_idx;
    logic [1:0]    r_off;
    logic [3:0]    r_be;
    logic          r_sext;
    logic [31:0]   r_wdata;
    logic          r_rd;
    logic          r_wr;
    logic          r_err;
    logic [31:0]   r_rdata;
    logic [31:0]   r_mem [DEPTH_WORDS];

    logic          w_accept;
    logic          w_from_in;
    logic [AW-1:0] w_c_idx;
    logic [1:0]    w_c_off;
    logic [3:0]    w_c_be;
    logic [31:0]   w_c_wdata;
    logic          w_c_wr;
    logic          w_c_err;
    logic          w_in_err;
    logic          w_enter_resp;
    logic          w_we;
    logic [3:0]    w_lanes;
    logic [31:0]   w_wdata_sh;
    logic [31:0]   w_align;
    logic          w_unused;

    assign w_unused = ^req_addr[31:AW+2];

    assign w_accept = req_valid && (r_state == IDLE);
    assign w_in_err = f_illegal(req_rd_en, req_wr_en,
                                req_byte_en, req_addr[1:0]);

    always_comb begin
        w_next    = r_state;
        w_cnt_nxt = 3'd0;
        unique case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_next    = (WC != 3'd0) ? WAIT : RESP;
                    w_cnt_nxt = 3'd1;
                end
            end
            WAIT: begin
                if (r_cnt == WC) begin
                    w_next = RESP;
                end else begin
                    w_cnt_nxt = r_cnt + 3'd1;
                end
            end
            RESP:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= 3'd0;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idx   <= '0;
            r_off   <= 2'b00;
            r_be    <= 4'b0000;
            r_sext  <= 1'b0;
            r_wdata <= 32'd0;
            r_rd    <= 1'b0;
            r_wr    <= 1'b0;
            r_err   <= 1'b0;
        end else if (w_accept) begin
            r_idx   <= req_addr[AW+1:2];
            r_off   <= req_addr[1:0];
            r_be    <= req_byte_en;
            r_sext  <= req_sign_ext;
            r_wdata <= req_wr_data;
            r_rd    <= req_rd_en;
            r_wr    <= req_wr_en;
            r_err   <= w_in_err;
        end
    end

    // With no wait states the RAM is touched on the accept edge itself,
    // before the capture registers hold the request.
    assign w_from_in = (r_state == IDLE);
    assign w_c_idx   = w_from_in ? req_addr[AW+1:2] : r_idx;
    assign w_c_off   = w_from_in ? req_addr[1:0]    : r_off;
    assign w_c_be    = w_from_in ? req_byte_en      : r_be;
    assign w_c_wdata = w_from_in ? req_wr_data      : r_wdata;
    assign w_c_wr    = w_from_in ? req_wr_en        : r_wr;
    assign w_c_err   = w_from_in ? w_in_err         : r_err;

    assign w_enter_resp = !rst && (w_next == RESP) && (r_state != RESP);
    assign w_we         = w_enter_resp && w_c_wr && !w_c_err;
    assign w_lanes      = 4'(w_c_be << w_c_off);
    assign w_wdata_sh   = w_c_wdata << {w_c_off, 3'b000};

    always_ff @(posedge clk) begin
        if (w_we) begin
            for (int b = 0; b < 4; b++) begin
                if (w_lanes[b]) begin
                    r_mem[w_c_idx][8*b +: 8] <= w_wdata_sh[8*b +: 8];
                end
            end
        end
        if (w_enter_resp) begin
            r_rdata <= r_mem[w_c_idx];
        end
    end

    rv_dmem_align u_align (
        .i_word (r_rdata),
        .i_off  (r_off),
        .i_be   (r_be),
        .i_sext (r_sext),
        .o_data (w_align)
    );

    assign req_ready   = (r_state == IDLE);
    assign rsp_valid   = (r_state == RESP);
    assign rsp_err     = rsp_valid && r_err;
    assign rsp_rd_data = (rsp_valid && r_rd && !r_err) ? w_align : 32'd0;

endmodule

// File: tb/tb_rv_dmem_resp.sv
// Directed bench for rv_dmem_resp: vector table on a one-wait-state
// instance, plus reset-in-flight and back-to-back zero-wait sequences.
module tb_rv_dmem_resp;
    import rv_dmem_pkg::*;

    typedef struct {
        logic [31:0] addr;
        logic        rd;
        logic        wr;
        logic [3:0]  be;
        logic        sext;
        logic [31:0] wdata;
        logic [31:0] exp_data;
        logic        exp_err;
    } t_vec;

    logic        clk;
    logic        rst;
    logic        valid;
    logic        ready;
    logic [31:0] addr;
    logic        rd;
    logic        wr;
    logic [3:0]  be;
    logic        sext;
    logic [31:0] wdata;
    logic        rvalid;
    logic [31:0] rdata;
    logic        err;

    logic        v0;
    logic        ready0;
    logic [31:0] addr0;
    logic        rd0;
    logic        wr0;
    logic [3:0]  be0;
    logic        sext0;
    logic [31:0] wdata0;
    logic        rvalid0;
    logic [31:0] rdata0;
    logic        err0;

    int n_cmp;
    int n_bad;

    rv_dmem_resp #(.DEPTH_WORDS(1024), .WAIT_CYCLES(1)) u_dut (
        .clk(clk), .rst(rst),
        .req_valid(valid), .req_ready(ready),
        .req_addr(addr), .req_rd_en(rd), .req_wr_en(wr),
        .req_byte_en(be), .req_sign_ext(sext), .req_wr_data(wdata),
        .rsp_valid(rvalid), .rsp_rd_data(rdata), .rsp_err(err)
    );

    rv_dmem_resp #(.DEPTH_WORDS(1024), .WAIT_CYCLES(0)) u_dut0 (
        .clk(clk), .rst(rst),
        .req_valid(v0), .req_ready(ready0),
        .req_addr(addr0), .req_rd_en(rd0), .req_wr_en(wr0),
        .req_byte_en(be0), .req_sign_ext(sext0), .req_wr_data(wdata0),
        .rsp_valid(rvalid0), .rsp_rd_data(rdata0), .rsp_err(err0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic t_vec mk(
        input logic [31:0] a, input logic r, input logic w,
        input logic [3:0] b, input logic s, input logic [31:0] d,
        input logic [31:0] ed, input logic ee);
        t_vec v;
        v.addr = a; v.rd = r; v.wr = w; v.be = b; v.sext = s;
        v.wdata = d; v.exp_data = ed; v.exp_err = ee;
        return v;
    endfunction

    task automatic do_req(
        input  logic [31:0] a, input logic r, input logic w,
        input  logic [3:0] b, input logic s, input logic [31:0] d,
        output logic [31:0] o_data, output logic o_err,
        output int o_lat, output logic o_quiet, output logic o_rdy);
        int k;
        o_data = 32'd0; o_err = 1'b0; o_lat = -1;
        o_quiet = 1'b1; o_rdy = 1'b0;
        @(negedge clk);
        addr = a; rd = r; wr = w; be = b; sext = s; wdata = d;
        valid = 1'b1;
        k = 0;
        while (!ready && k < 20) begin
            @(negedge clk);
            k++;
        end
        if (!ready) begin
            n_cmp++; n_bad++;
            $display("FAIL req_timeout: ready stuck at %b", ready);
            valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        valid = 1'b0;
        addr = ~a; rd = ~r; wr = ~w; be = ~b; sext = ~s; wdata = ~d;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (rvalid) begin
                o_lat = i; o_data = rdata; o_err = err;
                break;
            end
            if (rdata != 32'd0 || err) o_quiet = 1'b0;
        end
        @(negedge clk);
        o_rdy = ready;
        if (rdata != 32'd0 || err) o_quiet = 1'b0;
    endtask

    t_vec        vt[20];
    logic [31:0] g_data;
    logic        g_err;
    int          g_lat;
    logic        g_quiet;
    logic        g_rdy;
    logic        seen;
    int          n_acc;

    initial begin
        n_cmp = 0; n_bad = 0;
        vt[0]  = mk(32'h10,   1'b0, 1'b1, BE_WORD, 1'b0, 32'hDEADBEEF, 32'h0, 1'b0);
        vt[1]  = mk(32'h10,   1'b1, 1'b0, BE_WORD, 1'b0, 32'h0, 32'hDEADBEEF, 1'b0);
        vt[2]  = mk(32'h13,   1'b1, 1'b0, BE_BYTE, 1'b1, 32'h0, 32'hFFFFFFDE, 1'b0);
        vt[3]  = mk(32'h13,   1'b1, 1'b0, BE_BYTE, 1'b0, 32'h0, 32'h000000DE, 1'b0);
        vt[4]  = mk(32'h12,   1'b1, 1'b0, BE_HALF, 1'b1, 32'h0, 32'hFFFFDEAD, 1'b0);
        vt[5]  = mk(32'h10,   1'b1, 1'b0, BE_HALF, 1'b0, 32'h0, 32'h0000BEEF, 1'b0);
        vt[6]  = mk(32'h11,   1'b0, 1'b1, BE_BYTE, 1'b0, 32'hFFFFFF55, 32'h0, 1'b0);
        vt[7]  = mk(32'h10,   1'b1, 1'b0, BE_WORD, 1'b0, 32'h0, 32'hDEAD55EF, 1'b0);
        vt[8]  = mk(32'h12,   1'b1, 1'b0, BE_WORD, 1'b0, 32'h0, 32'h0, 1'b1);
        vt[9]  = mk(32'h11,   1'b0, 1'b1, BE_HALF, 1'b0, 32'h1234, 32'h0, 1'b1);
        vt[10] = mk(32'h10,   1'b1, 1'b0, BE_WORD, 1'b0, 32'h0, 32'hDEAD55EF, 1'b0);
        vt[11] = mk(32'h10,   1'b1, 1'b1, BE_WORD, 1'b0, 32'h0, 32'h0, 1'b1);
        vt[12] = mk(32'h10,   1'b0, 1'b0, BE_WORD, 1'b0, 32'h0, 32'h0, 1'b1);
        vt[13] = mk(32'h10,   1'b1, 1'b0, 4'b0111, 1'b0, 32'h0, 32'h0, 1'b1);
        vt[14] = mk(32'h12,   1'b0, 1'b1, BE_HALF, 1'b0, 32'h9999CAFE, 32'h0, 1'b0);
        vt[15] = mk(32'h1010, 1'b1, 1'b0, BE_WORD, 1'b0, 32'h0, 32'hCAFE55EF, 1'b0);
        vt[16] = mk(32'h1014, 1'b0, 1'b1, BE_WORD, 1'b0, 32'h01234567, 32'h0, 1'b0);
        vt[17] = mk(32'h14,   1'b1, 1'b0, BE_BYTE, 1'b1, 32'h0, 32'h00000067, 1'b0);
        vt[18] = mk(32'h16,   1'b1, 1'b0, BE_HALF, 1'b1, 32'h0, 32'h00000123, 1'b0);
        vt[19] = mk(32'h13,   1'b1, 1'b0, BE_HALF, 1'b1, 32'h0, 32'h0, 1'b1);

        valid = 1'b0; addr = 32'd0; rd = 1'b0; wr = 1'b0;
        be = 4'd0; sext = 1'b0; wdata = 32'd0;
        v0 = 1'b0; addr0 = 32'd0; rd0 = 1'b1; wr0 = 1'b0;
        be0 = BE_WORD; sext0 = 1'b0; wdata0 = 32'd0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("reset_ready", {31'd0, ready}, 32'd1);
        chk("reset_rsp_valid", {31'd0, rvalid}, 32'd0);
        chk("reset_rd_data", rdata, 32'd0);
        chk("reset_err", {31'd0, err}, 32'd0);
        chk("reset_ready0", {31'd0, ready0}, 32'd1);
        rst = 1'b0;

        for (int i = 0; i < 20; i++) begin
            do_req(vt[i].addr, vt[i].rd, vt[i].wr, vt[i].be, vt[i].sext,
                   vt[i].wdata, g_data, g_err, g_lat, g_quiet, g_rdy);
            chk($sformatf("v%0d_data", i), g_data, vt[i].exp_data);
            chk($sformatf("v%0d_err", i), {31'd0, g_err},
                {31'd0, vt[i].exp_err});
            chk($sformatf("v%0d_latency", i), 32'(g_lat), 32'd2);
            chk($sformatf("v%0d_quiet", i), {31'd0, g_quiet}, 32'd1);
            chk($sformatf("v%0d_ready_after", i), {31'd0, g_rdy}, 32'd1);
        end

        do_req(32'h20, 1'b0, 1'b1, BE_WORD, 1'b0, 32'hAAAA5555,
               g_data, g_err, g_lat, g_quiet, g_rdy);
        chk("pre_store_err", {31'd0, g_err}, 32'd0);
        @(negedge clk);
        addr = 32'h20; rd = 1'b0; wr = 1'b1; be = BE_WORD;
        sext = 1'b0; wdata = 32'h11111111; valid = 1'b1;
        chk("rst_seq_ready_idle", {31'd0, ready}, 32'd1);
        @(posedge clk);
        #1;
        valid = 1'b0;
        @(negedge clk);
        chk("rst_seq_in_wait_ready", {31'd0, ready}, 32'd0);
        rst = 1'b1;
        #1;
        chk("rst_seq_ready", {31'd0, ready}, 32'd1);
        chk("rst_seq_rsp_valid", {31'd0, rvalid}, 32'd0);
        chk("rst_seq_rd_data", rdata, 32'd0);
        chk("rst_seq_err", {31'd0, err}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (rvalid) seen = 1'b1;
        end
        chk("rst_seq_no_rsp", {31'd0, seen}, 32'd0);
        do_req(32'h20, 1'b1, 1'b0, BE_WORD, 1'b0, 32'h0,
               g_data, g_err, g_lat, g_quiet, g_rdy);
        chk("rst_seq_mem_kept", g_data, 32'hAAAA5555);

        @(negedge clk);
        v0 = 1'b1;
        n_acc = 0;
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("b2b_ready_%0d", i), {31'd0, ready0},
                {31'd0, (i % 2 == 0)});
            chk($sformatf("b2b_rsp_valid_%0d", i), {31'd0, rvalid0},
                {31'd0, (i % 2 == 1)});
            if (rvalid0) chk($sformatf("b2b_err_%0d", i), {31'd0, err0}, 32'd0);
            if (ready0 && v0) n_acc++;
            @(negedge clk);
        end
        v0 = 1'b0;
        chk("b2b_accepts", 32'(n_acc), 32'd4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
